// File: rtl/keypad_pkg.sv
// ============================================================================
// keypad_pkg : shared types, key-code field positions and decode helper
// Revision   : 1.0
// ============================================================================
`default_nettype none

package keypad_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRESS = 2'd1,
    GAP   = 2'd2
  } kp_state_t;

  localparam int ROW_MSB = 3;
  localparam int ROW_LSB = 2;
  localparam int COL_MSB = 1;
  localparam int COL_LSB = 0;

  localparam logic [3:0] SCAN_START_COL = 4'b0001;

  function automatic logic [3:0] onehot4(input logic [1:0] idx);
    onehot4 = 4'b0001 << idx;
  endfunction

endpackage

`default_nettype wire

// File: rtl/keypad_fifo.sv
// ============================================================================
// keypad_fifo : small synchronous FIFO for queued key codes (wrap-bit pointers)
// Revision    : 1.0
// ============================================================================
`default_nettype none

module keypad_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int          AW      = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             w_do_push;
  logic             w_do_pop;

  // Extra pointer MSB tells a full queue apart from an empty one.
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign pop_data = mem_q[rd_ptr_q[AW-1:0]];

  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (w_do_push) begin
        mem_d[wr_ptr_q[AW-1:0]] = push_data;
        wr_ptr_d                = wr_ptr_q + PTR_ONE;
      end
      if (w_do_pop) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/keypad_emulator.sv
// ============================================================================
// keypad_emulator : answers scanner column strobes with row lines so the
//                   scanner sees a queued sequence of timed key presses
// Revision        : 1.0
// ============================================================================
`default_nettype none

module keypad_emulator
  import keypad_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int HOLD_SCANS = 8,
  parameter int GAP_SCANS  = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic       key_ready,
  input  logic       abort,
  input  logic [3:0] col,
  output logic [3:0] fila,
  output logic       busy,
  output logic       pressed
);

  localparam logic [7:0] HOLD_CNT = 8'(HOLD_SCANS);
  localparam logic [7:0] GAP_CNT  = 8'(GAP_SCANS);

  kp_state_t  state_q, state_d;
  logic [3:0] cur_code_q, cur_code_d;
  logic [7:0] scan_cnt_q, scan_cnt_d;
  logic [3:0] prev_col_q, prev_col_d;

  logic       w_pop;
  logic [3:0] w_pop_data;
  logic       w_full;
  logic       w_empty;
  logic       w_scan_start;

  keypad_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (4)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (key_valid),
    .push_data (key_code),
    .pop       (w_pop),
    .flush     (abort),
    .pop_data  (w_pop_data),
    .full      (w_full),
    .empty     (w_empty)
  );

  // A long C1 strobe counts once: only the transition into C1 starts a scan.
  assign w_scan_start = (col == SCAN_START_COL) && (prev_col_q != SCAN_START_COL);

  always_comb begin
    state_d    = state_q;
    cur_code_d = cur_code_q;
    scan_cnt_d = scan_cnt_q;
    prev_col_d = col;
    w_pop      = 1'b0;

    if (w_scan_start) begin
      scan_cnt_d = scan_cnt_q + 8'd1;
    end

    if (abort) begin
      state_d    = IDLE;
      scan_cnt_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!w_empty) begin
            w_pop      = 1'b1;
            cur_code_d = w_pop_data;
            scan_cnt_d = '0;
            state_d    = PRESS;
          end
        end
        PRESS: begin
          if (w_scan_start && (scan_cnt_q == HOLD_CNT)) begin
            scan_cnt_d = '0;
            state_d    = GAP;
          end
        end
        GAP: begin
          if (w_scan_start && (scan_cnt_q == GAP_CNT)) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cur_code_q <= '0;
      scan_cnt_q <= '0;
      prev_col_q <= '0;
    end else begin
      state_q    <= state_d;
      cur_code_q <= cur_code_d;
      scan_cnt_q <= scan_cnt_d;
      prev_col_q <= prev_col_d;
    end
  end

  // Exact match with the key's column also rejects idle and multi-hot strobes.
  always_comb begin
    fila = 4'b0000;
    if ((state_q == PRESS) && (col == onehot4(cur_code_q[COL_MSB:COL_LSB]))) begin
      fila = onehot4(cur_code_q[ROW_MSB:ROW_LSB]);
    end
  end

  assign key_ready = !w_full;
  assign busy      = (state_q != IDLE) || !w_empty;
  assign pressed   = (state_q == PRESS);

endmodule

`default_nettype wire

// File: tb/tb_keypad_emulator.sv
// ============================================================================
// tb_keypad_emulator : directed bench for keypad_emulator (HOLD 2, GAP 1, depth 4)
// Revision           : 1.0
// ============================================================================
`default_nettype none

module tb_keypad_emulator;

  logic       clk;
  logic       rst_n;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_ready;
  logic       abort;
  logic [3:0] col;
  logic [3:0] fila;
  logic       busy;
  logic       pressed;

  int n_vec = 0;
  int n_err = 0;

  keypad_emulator #(
    .FIFO_DEPTH (4),
    .HOLD_SCANS (2),
    .GAP_SCANS  (1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_ready (key_ready),
    .abort     (abort),
    .col       (col),
    .fila      (fila),
    .busy      (busy),
    .pressed   (pressed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] code);
    key_valid = 1'b1;
    key_code  = code;
    tick;
    key_valid = 1'b0;
  endtask

  // One full scan, two cycles per column; fila is sampled in the second cycle,
  // packed as {C4,C3,C2,C1} rows.
  task automatic run_scan(output logic [15:0] seen);
    seen = '0;
    for (int c = 0; c < 4; c++) begin
      col = 4'b0001 << c;
      tick;
      seen[c*4 +: 4] = fila;
      tick;
    end
  endtask

  // Lead key F3C2 then F1C1, F2C2, F3C3, F4C4; five scans per key.
  logic [15:0] exp_b [25] = '{
    16'h0040, 16'h0040, 16'h0000, 16'h0000, 16'h0000,
    16'h0001, 16'h0001, 16'h0000, 16'h0000, 16'h0020,
    16'h0020, 16'h0020, 16'h0000, 16'h0000, 16'h0400,
    16'h0400, 16'h0400, 16'h0000, 16'h0000, 16'h8000,
    16'h8000, 16'h8000, 16'h0000, 16'h0000, 16'h0000
  };
  logic [15:0] exp_a [5] = '{16'h0200, 16'h0200, 16'h0000, 16'h0000, 16'h0000};
  logic [15:0] exp_c [5] = '{16'h1000, 16'h1000, 16'h0000, 16'h0000, 16'h0800};

  logic [15:0] seen;

  initial begin
    rst_n     = 1'b0;
    key_valid = 1'b0;
    key_code  = 4'h0;
    abort     = 1'b0;
    col       = 4'b0000;

    // Reset while the scanner keeps strobing
    for (int c = 0; c < 4; c++) begin
      col = 4'b0001 << c;
      tick;
      check_vec($sformatf("rst_fila_c%0d", c), 16'(fila), 16'h0000);
    end
    check_vec("rst_key_ready", 16'(key_ready), 16'h1);
    check_vec("rst_busy", 16'(busy), 16'h0);
    check_vec("rst_pressed", 16'(pressed), 16'h0);
    col = 4'b0000;
    tick;
    rst_n = 1'b1;
    tick;

    // Single key F2C3
    push(4'b0110);
    check_vec("a_busy_after_push", 16'(busy), 16'h1);
    check_vec("a_pressed_after_push", 16'(pressed), 16'h0);
    tick;
    check_vec("a_pressed_after_pop", 16'(pressed), 16'h1);
    for (int s = 0; s < 5; s++) begin
      run_scan(seen);
      check_vec($sformatf("a_scan%0d", s + 1), seen, exp_a[s]);
      if (s == 2) check_vec("a_pressed_gap", 16'(pressed), 16'h0);
      if (s == 3) check_vec("a_busy_gap", 16'(busy), 16'h1);
    end
    check_vec("a_busy_done", 16'(busy), 16'h0);
    col = 4'b0000;
    tick;

    // Lead key then four queued keys filling the queue
    push(4'b1001);
    tick;
    check_vec("b_lead_pressed", 16'(pressed), 16'h1);
    push(4'b0000);
    push(4'b0101);
    push(4'b1010);
    check_vec("b_ready_3", 16'(key_ready), 16'h1);
    push(4'b1111);
    check_vec("b_ready_full", 16'(key_ready), 16'h0);
    push(4'b0111);
    check_vec("b_ready_still_full", 16'(key_ready), 16'h0);
    for (int s = 0; s < 25; s++) begin
      run_scan(seen);
      check_vec($sformatf("b_scan%0d", s + 1), seen, exp_b[s]);
    end
    check_vec("b_busy_done", 16'(busy), 16'h0);
    check_vec("b_ready_done", 16'(key_ready), 16'h1);
    col = 4'b0000;
    tick;

    // Push coinciding with the IDLE pop, then abort with two codes queued
    push(4'b0011);
    push(4'b1110);
    check_vec("c_pressed", 16'(pressed), 16'h1);
    push(4'b0100);
    push(4'b1101);
    for (int s = 0; s < 5; s++) begin
      run_scan(seen);
      check_vec($sformatf("c_scan%0d", s + 1), seen, exp_c[s]);
    end
    col = 4'b0100;
    #1;
    check_vec("c_second_key_fila", 16'(fila), 16'h8);
    abort     = 1'b1;
    key_valid = 1'b1;
    key_code  = 4'b0101;
    tick;
    abort     = 1'b0;
    key_valid = 1'b0;
    check_vec("c_abort_fila", 16'(fila), 16'h0);
    check_vec("c_abort_busy", 16'(busy), 16'h0);
    check_vec("c_abort_pressed", 16'(pressed), 16'h0);
    tick;
    tick;
    tick;
    check_vec("c_abort_discard", 16'(busy), 16'h0);

    // Later push still works; illegal strobes and async reset
    col = 4'b0000;
    push(4'b0001);
    tick;
    check_vec("d_pressed", 16'(pressed), 16'h1);
    col = 4'b0010;
    #1;
    check_vec("d_fila_c2", 16'(fila), 16'h1);
    col = 4'b0011;
    #1;
    check_vec("d_fila_multihot", 16'(fila), 16'h0);
    col = 4'b0000;
    #1;
    check_vec("d_fila_none", 16'(fila), 16'h0);
    col = 4'b0010;
    #1;
    check_vec("d_fila_c2_again", 16'(fila), 16'h1);
    #1;
    rst_n = 1'b0;
    #1;
    check_vec("d_async_rst_fila", 16'(fila), 16'h0);
    check_vec("d_async_rst_pressed", 16'(pressed), 16'h0);
    tick;
    rst_n = 1'b1;
    tick;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
